// File: rtl/wb_pkg.sv
// Shared types and defaults for the two-master Wishbone round-robin arbiter.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        ABORT = 2'd3
    } owner_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/wb_watchdog.sv
// Stall/ack watchdog: counts idle bus cycles while the downstream cycle is open
// and flags a timeout on the cycle the count reaches TIMEOUT_CYCLES-1.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_areset_n,
    input  logic i_active,
    input  logic i_clear,
    output logic o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_timeout = i_active && (cnt_q == LIMIT);
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q + CW'(1);
        if (!i_active || i_clear || o_timeout) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with zero-latency pass-through after grant.
// Optional watchdog abort is built when WB_RR_ARBITER_TIMEOUT_EN is defined.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_areset_n,
    input  logic          i_a_cyc,
    input  logic          i_a_stb,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_data,
    output logic          o_a_ack,
    output logic          o_a_stall,
    output logic          o_a_err,
    input  logic          i_b_cyc,
    input  logic          i_b_stb,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_data,
    output logic          o_b_ack,
    output logic          o_b_stall,
    output logic          o_b_err,
    output logic [DW-1:0] o_rdata,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    input  logic          i_wb_ack,
    input  logic          i_wb_stall,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data
);

    owner_e state_q, state_d;
    logic   last_b_q, last_b_d;
    logic   own_a, own_b;
    logic   timeout;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    logic wd_clear;

    assign wd_clear = (state_q == IDLE) || i_wb_ack || i_wb_err || (o_wb_stb && !i_wb_stall);

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_active   (o_wb_cyc),
        .i_clear    (wd_clear),
        .o_timeout  (timeout)
    );
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    assign own_a = (state_q == OWN_A);
    assign own_b = (state_q == OWN_B);

    // Bus side is a pure mux of the owning master; nothing is registered here.
    always_comb begin
        o_wb_cyc  = (own_a && i_a_cyc) || (own_b && i_b_cyc);
        o_wb_stb  = (own_a && i_a_cyc && i_a_stb) || (own_b && i_b_cyc && i_b_stb);
        o_wb_we   = own_b ? i_b_we   : i_a_we;
        o_wb_addr = own_b ? i_b_addr : i_a_addr;
        o_wb_data = own_b ? i_b_data : i_a_data;
        o_rdata   = i_wb_data;

        o_a_stall = own_a ? i_wb_stall : 1'b1;
        o_b_stall = own_b ? i_wb_stall : 1'b1;
        o_a_ack   = own_a && i_a_cyc && i_wb_ack;
        o_b_ack   = own_b && i_b_cyc && i_wb_ack;
        o_a_err   = own_a && ((i_a_cyc && i_wb_err) || timeout);
        o_b_err   = own_b && ((i_b_cyc && i_wb_err) || timeout);
    end

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        case (state_q)
            IDLE: begin
                if (i_a_cyc && (!i_b_cyc || last_b_q)) begin
                    state_d  = OWN_A;
                    last_b_d = 1'b0;
                end else if (i_b_cyc) begin
                    state_d  = OWN_B;
                    last_b_d = 1'b1;
                end
            end
            OWN_A: begin
                if (timeout) begin
                    state_d  = ABORT;
                    last_b_d = 1'b0;
                end else if (!i_a_cyc) begin
                    state_d  = i_b_cyc ? OWN_B : IDLE;
                    last_b_d = i_b_cyc;
                end
            end
            OWN_B: begin
                if (timeout) begin
                    state_d  = ABORT;
                    last_b_d = 1'b1;
                end else if (!i_b_cyc) begin
                    state_d  = i_a_cyc ? OWN_A : IDLE;
                    last_b_d = !i_a_cyc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
        end
    end

endmodule
